// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
//   state_t         - sequencer states (RUN, MEM_WAIT, BR_FLUSH)
//   REG_ADDR_W_DEF  - default register-file address width
//   ZERO_REG        - hard-wired zero register; never a hazard source
//   WAIT_W          - width of the memory wait counter (timeouts up to 255)
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    localparam int REG_ADDR_W_DEF = 4;
    localparam logic [REG_ADDR_W_DEF-1:0] ZERO_REG = '0;
    localparam int WAIT_W = 8;

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational load-use comparator.
//   idex_mem_read - instruction in EX is a load
//   idex_rd       - its destination register
//   ifid_rs1/rs2  - sources of the instruction in ID
//   ifid_use_rs2  - ID instruction actually reads rs2
//   hazard        - ID must wait one cycle for the load result
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  ifid_use_rs2,
    output logic                  hazard
);

    logic rd_live;
    logic rs1_match;
    logic rs2_match;

    // Writes to the zero register are discarded, so they never create a hazard.
    assign rd_live   = idex_rd != REG_ADDR_W'(ZERO_REG);
    assign rs1_match = idex_rd == ifid_rs1;
    assign rs2_match = ifid_use_rs2 && (idex_rd == ifid_rs2);
    assign hazard    = idex_mem_read && rd_live && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central sequencer for the 5-stage 16-bit pipeline.
// Generates PC / pipeline-register enables, flushes and the MEM/WB bubble from
// load-use hazards, taken branches and the data-memory wait handshake.
// Outputs are combinational from the registered state and the current inputs.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   idex_*/ifid_* inputs        - operand info for load-use detection
//   branch_taken_in             - taken branch resolved in EX
//   mem_req_in, mem_ready_in    - data-memory handshake
//   pc_en_out, ifid_en_out, exmem_en_out          - load enables
//   ifid_flush_out, idex_flush_out                - register clears
//   memwb_bubble_out            - forces an empty MEM/WB slot
//   mem_timeout_out             - pulse when a memory access is abandoned
//   stall_count_out             - saturating stall-cycle counter
// Optional: define STALL_COUNT_EN to include stall_count_out and its counter.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idex_memRead_in,
    input  logic [REG_ADDR_W-1:0] idex_rd_in,
    input  logic [REG_ADDR_W-1:0] ifid_rs1_in,
    input  logic [REG_ADDR_W-1:0] ifid_rs2_in,
    input  logic                  ifid_useRs2_in,
    input  logic                  branch_taken_in,
    input  logic                  mem_req_in,
    input  logic                  mem_ready_in,
    output logic                  pc_en_out,
    output logic                  ifid_en_out,
    output logic                  ifid_flush_out,
    output logic                  idex_flush_out,
    output logic                  exmem_en_out,
    output logic                  memwb_bubble_out,
`ifdef STALL_COUNT_EN
    output logic [CNT_W-1:0]      stall_count_out,
`endif
    output logic                  mem_timeout_out
);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              load_use;
    logic              mem_stall;
    logic              wait_expired;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .idex_mem_read (idex_memRead_in),
        .idex_rd       (idex_rd_in),
        .ifid_rs1      (ifid_rs1_in),
        .ifid_rs2      (ifid_rs2_in),
        .ifid_use_rs2  (ifid_useRs2_in),
        .hazard        (load_use)
    );

    assign mem_stall = mem_req_in && !mem_ready_in;

    // wait_cnt holds completed wait cycles, so the current cycle is number
    // wait_cnt+1; the abort fires on the MEM_TIMEOUT-th consecutive wait cycle.
    assign wait_expired = ({1'b0, wait_cnt_reg} + (WAIT_W+1)'(1)) >= (WAIT_W+1)'(MEM_TIMEOUT);

    always_comb begin
        pc_en_out        = 1'b1;
        ifid_en_out      = 1'b1;
        ifid_flush_out   = 1'b0;
        idex_flush_out   = 1'b0;
        exmem_en_out     = 1'b1;
        memwb_bubble_out = 1'b0;
        mem_timeout_out  = 1'b0;
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;

        if (rst) begin
            pc_en_out        = 1'b0;
            ifid_en_out      = 1'b0;
            exmem_en_out     = 1'b0;
            ifid_flush_out   = 1'b1;
            idex_flush_out   = 1'b1;
            memwb_bubble_out = 1'b1;
            state_next       = RUN;
            wait_cnt_next    = '0;
        end else begin
            case (state_reg)
                RUN, BR_FLUSH: begin
                    if (mem_stall) begin
                        if (MEM_TIMEOUT <= 1) begin
                            // A single allowed wait cycle is already exhausted.
                            mem_timeout_out  = 1'b1;
                            memwb_bubble_out = 1'b1;
                            state_next       = RUN;
                            wait_cnt_next    = '0;
                        end else begin
                            pc_en_out        = 1'b0;
                            ifid_en_out      = 1'b0;
                            exmem_en_out     = 1'b0;
                            memwb_bubble_out = 1'b1;
                            state_next       = MEM_WAIT;
                            wait_cnt_next    = WAIT_W'(1);
                        end
                    end else if (state_reg == BR_FLUSH) begin
                        // Wrong-path slot: defaults, branch input ignored.
                        state_next = RUN;
                    end else if (branch_taken_in) begin
                        // Branch beats load-use: the stalled instruction is wrong-path anyway.
                        ifid_flush_out = 1'b1;
                        idex_flush_out = 1'b1;
                        state_next     = BR_FLUSH;
                    end else if (load_use) begin
                        pc_en_out      = 1'b0;
                        ifid_en_out    = 1'b0;
                        idex_flush_out = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready_in) begin
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else if (wait_expired) begin
                        // Enables stay high so the aborted instruction is dropped.
                        mem_timeout_out  = 1'b1;
                        memwb_bubble_out = 1'b1;
                        state_next       = RUN;
                        wait_cnt_next    = '0;
                    end else begin
                        // ID/EX is held (not flushed) so a pending branch survives the freeze.
                        pc_en_out        = 1'b0;
                        ifid_en_out      = 1'b0;
                        exmem_en_out     = 1'b0;
                        memwb_bubble_out = 1'b1;
                        wait_cnt_next    = wait_cnt_reg + WAIT_W'(1);
                    end
                end
                default: begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_reg    <= state_next;
        wait_cnt_reg <= wait_cnt_next;
    end

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (!pc_en_out && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_count_out = stall_cnt_reg;
`endif

endmodule
